// File: rtl/cmd_fetch_pkg.sv
// Shared constants and state encoding for the command fetcher.
// The burst length and MCB instruction codes here are also what csb decodes against.
package cmd_fetch_pkg;

  localparam int          CMD_BURST_LEN   = 8;
  localparam logic [2:0]  MCB_RD          = 3'b001;
  localparam logic [2:0]  MCB_WR          = 3'b000;
  localparam logic [29:0] CMD_REGION_BASE = 30'h000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_FILL,
    S_STREAM,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/cmd_fetch_burst_buf.sv
// Burst buffer: DEPTH x DW register file with one write port and a registered read port.
// Read data holds its value while i_re is low, which keeps the last streamed word on cmd.
module cmd_burst_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cmd_fetch.sv
// Command fetcher: reads one BURST_LEN-word command from SDRAM over MCB port 1,
// buffers it, then streams it to csb as a gap-free run of ob_we strobes.
module cmd_fetch
  import cmd_fetch_pkg::*;
#(
  parameter logic [29:0] CMD_BASE  = CMD_REGION_BASE,
  parameter int          BURST_LEN = CMD_BURST_LEN,
  parameter int          IDX_W     = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [IDX_W-1:0] i_cmd_size,
  input  logic             i_dma_p1_reads_en,
  output logic             o_dma_p1_ob_we,
  output logic [31:0]      o_cmd,
  output logic             o_p1_cmd_en,
  output logic [2:0]       o_p1_cmd_instr,
  output logic [5:0]       o_p1_cmd_bl,
  output logic [29:0]      o_p1_cmd_byte_addr,
  input  logic             i_p1_cmd_full,
  output logic             o_p1_rd_en,
  input  logic [31:0]      i_p1_rd_data,
  input  logic             i_p1_rd_empty,
  output logic [IDX_W-1:0] o_cmd_idx,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int               CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BURST_LEN - 1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_wcnt, r_rcnt;
  logic [IDX_W-1:0] r_cmd_idx;
  logic             r_overrun, r_ob_we;
  logic [29:0]      r_addr;
  logic [5:0]       r_bl;
  logic [2:0]       r_instr;

  logic             w_cmd_en, w_pop, w_busy;
  logic             w_fill_done, w_stream_last;
  logic             w_buf_re;
  logic [CNT_W-1:0] w_buf_raddr;
  logic [31:0]      w_buf_rdata;

  assign w_fill_done   = w_pop && (r_wcnt == LAST);
  assign w_stream_last = (r_state == S_STREAM) && (r_rcnt == LAST);

  // buf[0] is fetched on the final pop so the first strobe carries valid data;
  // each stream cycle then prefetches the following word.
  assign w_buf_re    = w_fill_done || ((r_state == S_STREAM) && !w_stream_last);
  assign w_buf_raddr = (r_state == S_STREAM) ? r_rcnt + 1'b1 : '0;

  always_comb begin
    w_state_next = r_state;
    w_cmd_en     = 1'b0;
    w_pop        = 1'b0;
    w_busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (!i_start && i_dma_p1_reads_en && (r_cmd_idx < i_cmd_size)) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cmd_en = !i_p1_cmd_full;
        if (w_cmd_en) begin
          w_state_next = S_FILL;
        end
      end
      S_FILL: begin
        w_pop = !i_p1_rd_empty;
        if (w_pop && (r_wcnt == LAST)) begin
          w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (r_rcnt == LAST) begin
          w_state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!i_dma_p1_reads_en) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_cmd_idx <= '0;
      r_overrun <= 1'b0;
      r_ob_we   <= 1'b0;
      r_addr    <= '0;
      r_bl      <= '0;
      r_instr   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cmd_idx <= '0;
            r_overrun <= 1'b0;
          end else if (i_dma_p1_reads_en && (r_cmd_idx >= i_cmd_size)) begin
            r_overrun <= 1'b1;
          end else if (i_dma_p1_reads_en) begin
            r_addr  <= CMD_BASE + 30'(r_cmd_idx) * 30'(BURST_LEN * 4);
            r_bl    <= 6'(BURST_LEN - 1);
            r_instr <= MCB_RD;
          end
        end
        S_ISSUE: begin
          if (w_cmd_en) begin
            r_wcnt <= '0;
          end
        end
        S_FILL: begin
          if (w_pop) begin
            r_wcnt <= r_wcnt + 1'b1;
          end
          if (w_fill_done) begin
            r_rcnt  <= '0;
            r_ob_we <= 1'b1;
          end
        end
        S_STREAM: begin
          if (w_stream_last) begin
            r_ob_we   <= 1'b0;
            r_cmd_idx <= r_cmd_idx + 1'b1;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  cmd_burst_buf #(
    .DEPTH (BURST_LEN),
    .AW    (CNT_W),
    .DW    (32)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_pop),
    .i_waddr (r_wcnt),
    .i_wdata (i_p1_rd_data),
    .i_re    (w_buf_re),
    .i_raddr (w_buf_raddr),
    .o_rdata (w_buf_rdata)
  );

  assign o_dma_p1_ob_we     = r_ob_we;
  assign o_cmd              = w_buf_rdata;
  assign o_p1_cmd_en        = w_cmd_en;
  assign o_p1_cmd_instr     = r_instr;
  assign o_p1_cmd_bl        = r_bl;
  assign o_p1_cmd_byte_addr = r_addr;
  assign o_p1_rd_en         = w_pop;
  assign o_cmd_idx          = r_cmd_idx;
  assign o_busy             = w_busy;
  assign o_overrun          = r_overrun;

endmodule

// File: tb/tb_cmd_fetch.sv
// Bench for cmd_fetch: MCB port model plus scoreboards for addresses and streamed words.
module tb_cmd_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, reads_en, cmd_full, rd_empty;
  logic [6:0]  cmd_size;
  logic [31:0] rd_data;
  logic        ob_we, p1_cmd_en, p1_rd_en, busy, overrun;
  logic [31:0] cmd;
  logic [2:0]  p1_cmd_instr;
  logic [5:0]  p1_cmd_bl;
  logic [29:0] p1_cmd_byte_addr;
  logic [6:0]  cmd_idx;

  cmd_fetch dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start            (start),
    .i_cmd_size         (cmd_size),
    .i_dma_p1_reads_en  (reads_en),
    .o_dma_p1_ob_we     (ob_we),
    .o_cmd              (cmd),
    .o_p1_cmd_en        (p1_cmd_en),
    .o_p1_cmd_instr     (p1_cmd_instr),
    .o_p1_cmd_bl        (p1_cmd_bl),
    .o_p1_cmd_byte_addr (p1_cmd_byte_addr),
    .i_p1_cmd_full      (cmd_full),
    .o_p1_rd_en         (p1_rd_en),
    .i_p1_rd_data       (rd_data),
    .i_p1_rd_empty      (rd_empty),
    .o_cmd_idx          (cmd_idx),
    .o_busy             (busy),
    .o_overrun          (overrun)
  );

  typedef struct {
    logic [29:0] addr;
    logic [6:0]  idx_after;
    logic [31:0] base;
    bit          gaps;
    int          full;
  } req_t;

  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] mcb_q[$];
  logic [31:0] exp_cmd_q[$];
  logic [29:0] exp_addr_q[$];
  int          cmd_en_cnt = 0, pop_cnt = 0, bursts_done = 0, burst_pops = 0;
  int          last_pop_cyc = 0, run = 0, req_cyc = 0, exp_lat = -1, full_hold = 0;
  bit          gap_mode = 0, gap_phase = 0, issue_wait = 0;
  logic [31:0] word_base = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #2;
  endtask

  // MCB model and output monitor: drive at negedge, sample 1ns later.
  initial begin
    cmd_full = 1'b0;
    rd_empty = 1'b1;
    rd_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      cmd_full = (full_hold > 0);
      if (full_hold > 0) full_hold--;
      gap_phase = gap_mode ? !gap_phase : 1'b0;
      rd_empty  = (mcb_q.size() == 0) || gap_phase;
      rd_data   = (mcb_q.size() != 0) ? mcb_q[0] : 32'h0;
      #1;
      if (rst) begin
        run = 0;
      end else begin
        if (p1_cmd_en) begin
          cmd_en_cnt++;
          chk("cmd_en_while_full", 32'(cmd_full), 32'd0);
          if (exp_lat >= 0) chk("cmd_en_latency", 32'(cyc - req_cyc), 32'(exp_lat));
          exp_lat = -1;
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd_en: got pulse at addr 0x%0h, expected none", p1_cmd_byte_addr);
          end else begin
            chk("cmd_addr", 32'(p1_cmd_byte_addr), 32'(exp_addr_q.pop_front()));
          end
          chk("cmd_bl", 32'(p1_cmd_bl), 32'd7);
          chk("cmd_instr", 32'(p1_cmd_instr), 32'd1);
          issue_wait = 0;
          burst_pops = 0;
          for (int i = 0; i < 8; i++) begin
            mcb_q.push_back(word_base + 32'(i));
            exp_cmd_q.push_back(word_base + 32'(i));
          end
        end else if (issue_wait && busy && exp_addr_q.size() != 0) begin
          chk("addr_stable", 32'(p1_cmd_byte_addr), 32'(exp_addr_q[0]));
        end
        if (p1_rd_en) begin
          if (rd_empty) begin
            checks++;
            errors++;
            $display("FAIL pop_while_empty: got rd_en=1, expected 0");
          end
          if (mcb_q.size() != 0) void'(mcb_q.pop_front());
          pop_cnt++;
          burst_pops++;
          if (burst_pops == 8) last_pop_cyc = cyc;
        end
        if (ob_we) begin
          if (run == 0) chk("first_ob_we_latency", 32'(cyc), 32'(last_pop_cyc + 1));
          if (exp_cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ob_we: got cmd 0x%0h, expected no strobe", cmd);
          end else begin
            chk("cmd_word", cmd, exp_cmd_q.pop_front());
          end
          run++;
        end else if (run > 0) begin
          chk("ob_we_run_len", 32'(run), 32'd8);
          run = 0;
          bursts_done++;
        end
      end
    end
  end

  task automatic do_req(input req_t r);
    int pops0 = pop_cnt;
    int en0   = cmd_en_cnt;
    int done0 = bursts_done;
    int n     = 0;
    word_base  = r.base;
    gap_mode   = r.gaps;
    full_hold  = r.full;
    exp_lat    = 1 + r.full;
    exp_addr_q.push_back(r.addr);
    issue_wait = 1;
    reads_en   = 1'b1;
    req_cyc    = cyc;
    while (bursts_done == done0 && n < 300) begin
      tick;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got no complete burst, expected one within 300 cycles");
    end
    reads_en = 1'b0;
    gap_mode = 0;
    tick;
    tick;
    chk("req_cmd_idx", 32'(cmd_idx), 32'(r.idx_after));
    chk("req_busy_after", 32'(busy), 32'd0);
    chk("req_cmd_en_count", 32'(cmd_en_cnt - en0), 32'd1);
    chk("req_pop_count", 32'(pop_cnt - pops0), 32'd8);
    $display("request addr=0x%0h gaps=%0d full=%0d -> cmd_idx=%0d", r.addr, r.gaps, r.full, cmd_idx);
  endtask

  initial begin
    req_t tbl[3];
    int   en0, done0, n;
    tbl[0] = '{addr: 30'h00, idx_after: 7'd1, base: 32'h11, gaps: 1'b0, full: 0};
    tbl[1] = '{addr: 30'h20, idx_after: 7'd2, base: 32'h21, gaps: 1'b1, full: 0};
    tbl[2] = '{addr: 30'h40, idx_after: 7'd3, base: 32'h31, gaps: 1'b0, full: 5};

    rst = 1'b1; start = 1'b0; reads_en = 1'b0; cmd_size = 7'd0;
    repeat (3) tick;
    chk("rst_ob_we", 32'(ob_we), 32'd0);
    chk("rst_cmd", cmd, 32'd0);
    chk("rst_cmd_en", 32'(p1_cmd_en), 32'd0);
    chk("rst_rd_en", 32'(p1_rd_en), 32'd0);
    chk("rst_addr", 32'(p1_cmd_byte_addr), 32'd0);
    chk("rst_bl", 32'(p1_cmd_bl), 32'd0);
    chk("rst_instr", 32'(p1_cmd_instr), 32'd0);
    chk("rst_cmd_idx", 32'(cmd_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    $display("reset state checked");

    rst = 1'b0; cmd_size = 7'd3; start = 1'b1;
    tick;
    start = 1'b0;
    tick;

    for (int i = 0; i < 3; i++) do_req(tbl[i]);

    // Overrun: index has reached cmd_size.
    en0 = cmd_en_cnt;
    reads_en = 1'b1;
    repeat (10) tick;
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd0);
    chk("ovr_no_cmd_en", 32'(cmd_en_cnt - en0), 32'd0);
    reads_en = 1'b0;
    repeat (3) tick;
    chk("ovr_sticky", 32'(overrun), 32'd1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_clears_ovr", 32'(overrun), 32'd0);
    chk("start_rewinds_idx", 32'(cmd_idx), 32'd0);
    $display("overrun set/held/cleared, cmd_idx=%0d", cmd_idx);

    // Reset in the middle of a stream.
    do_req('{addr: 30'h00, idx_after: 7'd1, base: 32'h51, gaps: 1'b0, full: 0});
    word_base = 32'h61;
    exp_addr_q.push_back(30'h20);
    issue_wait = 1; exp_lat = 1; req_cyc = cyc;
    reads_en = 1'b1;
    n = 0;
    while (run != 3 && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL abort_timeout: got run=%0d, expected 3 words", run);
    end
    rst = 1'b1;
    tick;
    chk("abort_ob_we", 32'(ob_we), 32'd0);
    chk("abort_cmd", cmd, 32'd0);
    chk("abort_cmd_idx", 32'(cmd_idx), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0; reads_en = 1'b0;
    exp_cmd_q.delete();
    mcb_q.delete();
    tick;
    $display("reset mid-stream checked");

    // Request held high through RELEASE must be served once.
    en0 = cmd_en_cnt;
    done0 = bursts_done;
    word_base = 32'h71;
    exp_addr_q.push_back(30'h00);
    issue_wait = 1; exp_lat = 1; req_cyc = cyc;
    reads_en = 1'b1;
    n = 0;
    while (bursts_done == done0 && n < 300) begin
      tick;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL hold_timeout: got no burst, expected one within 300 cycles");
    end
    repeat (20) tick;
    chk("hold_single_cmd_en", 32'(cmd_en_cnt - en0), 32'd1);
    chk("hold_busy_release", 32'(busy), 32'd1);
    reads_en = 1'b0;
    tick;
    chk("hold_idle_after_drop", 32'(busy), 32'd0);
    chk("hold_cmd_idx", 32'(cmd_idx), 32'd1);
    $display("held request served once");
    do_req('{addr: 30'h20, idx_after: 7'd2, base: 32'h81, gaps: 1'b0, full: 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
